// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and bit-level functions for the SHA-256 core.
//   K_FLAT : the 64 round constants packed K[0]..K[63], K[0] in the top word
//   H0     : the standard initial chaining value {A,B,C,D,E,F,G,H}
//   big_sigma0/1, small_sigma0/1, ch, maj : the SHA-256 mixing functions
package sha256_pkg;

    localparam logic [64*32-1:0] K_FLAT = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Rotations are written as concatenations so they map to pure wiring.
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// sha256_k_rom: combinational lookup of the SHA-256 round constant K[address].
//   address : round index 0..63
//   value   : K[address]
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  address,
    output logic [31:0] value
);

    // K[0] sits in the top word, so word i starts at bit (63-i)*32 = {~i, 5'b0}.
    assign value = K_FLAT[{~address, 5'b00000} +: 32];

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: one SHA-256 compression round per clock for a single
// 512-bit block, with the message schedule expanded on the fly.
//   clk, rst_n : clock and synchronous active-low reset
//   counter    : round index t of the current cycle (0..63)
//   wordIn     : message word W_t, used only while t < 16
//   hashIn     : chaining value {A..H}, loaded while rst_n is low
//   ready      : high once round 63 has registered; state frozen from then on
//   stateOut   : {Aa,Ab,B,C,D,E,F,G,H}; A = Aa + Ab mod 2^32
//
// Sequencing contract: the parent presents round t on counter (and W_t on
// wordIn for t < 16) for exactly one cycle each, in order 0..63, starting the
// cycle after reset is released. ready rises on the edge that registers round
// 63 and then stays high, ignoring counter and wordIn, until the next reset.
module sha256_round_engine
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   counter,
    input  logic [31:0]  wordIn,
    input  logic [255:0] hashIn,
    output logic         ready,
    output logic [287:0] stateOut
);

    logic [31:0] aa_q, ab_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    // w_q[15] is W[t-1], w_q[0] is W[t-16] relative to the round being computed.
    logic [31:0] w_q [16];
    logic [5:0]  done_q;
    logic        ready_q;

    logic [31:0] k_t;
    logic [31:0] w_t;
    logic [31:0] a_val;
    logic [31:0] t1;
    logic [31:0] s0_a;
    logic [31:0] maj_abc;
    logic [31:0] csa_sum;
    logic [31:0] csa_maj;

    sha256_k_rom u_k_rom (
        .address (counter),
        .value   (k_t)
    );

    always_comb begin
        a_val = aa_q + ab_q;
        if (counter < 6'd16) begin
            w_t = wordIn;
        end else begin
            w_t = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
        end
        t1      = h_q + big_sigma1(e_q) + ch(e_q, f_q, g_q) + k_t + w_t;
        s0_a    = big_sigma0(a_val);
        maj_abc = maj(a_val, b_q, c_q);
        // T2 is never summed: the three terms T1, S0(A), Maj(A,B,C) are
        // folded by a 3:2 compressor and A stays in carry-save form.
        csa_sum = t1 ^ s0_a ^ maj_abc;
        csa_maj = (t1 & s0_a) | (t1 & maj_abc) | (s0_a & maj_abc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aa_q    <= hashIn[255:224];
            ab_q    <= 32'h0;
            b_q     <= hashIn[223:192];
            c_q     <= hashIn[191:160];
            d_q     <= hashIn[159:128];
            e_q     <= hashIn[127:96];
            f_q     <= hashIn[95:64];
            g_q     <= hashIn[63:32];
            h_q     <= hashIn[31:0];
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
            done_q  <= 6'd0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            aa_q <= csa_sum;
            ab_q <= csa_maj << 1;
            b_q  <= a_val;
            c_q  <= b_q;
            d_q  <= c_q;
            e_q  <= d_q + t1;
            f_q  <= e_q;
            g_q  <= f_q;
            h_q  <= g_q;
            for (int i = 0; i < 15; i++) begin
                w_q[i] <= w_q[i+1];
            end
            w_q[15] <= w_t;
            done_q  <= done_q + 6'd1;
            // The 64th round is the one registered while done_q still reads 63.
            if (done_q == 6'd63) begin
                ready_q <= 1'b1;
            end
        end
    end

    assign ready    = ready_q;
    assign stateOut = {aa_q, ab_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q};

endmodule

// File: tb/tb_sha256_round_engine.sv
module tb_sha256_round_engine;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [5:0]   counter = 6'd63;
    logic [31:0]  wordIn = 32'h0;
    logic [255:0] hashIn = 256'h0;
    logic         ready;
    logic [287:0] stateOut;

    logic [5:0]   rom_addr = 6'd0;
    logic [31:0]  rom_val;

    sha256_round_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .counter  (counter),
        .wordIn   (wordIn),
        .hashIn   (hashIn),
        .ready    (ready),
        .stateOut (stateOut)
    );

    sha256_k_rom rom (
        .address (rom_addr),
        .value   (rom_val)
    );

    // ---------------- reference data ----------------
    logic [255:0] h0_tb = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [255:0] abc_digest = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    logic [31:0] k_tb [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- behavioural model ----------------
    logic [31:0]  msg    [64];   // full expanded schedule W[0..63]
    logic [255:0] exp_st [65];   // exp_st[0] = chaining value, exp_st[t+1] = after round t

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
        end
        return r;
    endfunction

    task automatic build_model(input logic [255:0] h);
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(msg[t-15], 7) ^ rotr(msg[t-15], 18) ^ (msg[t-15] >> 3);
            s1 = rotr(msg[t-2], 17) ^ rotr(msg[t-2], 19) ^ (msg[t-2] >> 10);
            msg[t] = s1 + msg[t-7] + s0 + msg[t-16];
        end
        {a, b, c, d, e, f, g, hh} = h;
        exp_st[0] = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k_tb[t] + msg[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
            exp_st[t+1] = {a, b, c, d, e, f, g, hh};
        end
    endtask

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [256:0] exp_q [$];   // {ready, A, B..H} expected after the next edge

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        logic [256:0] e;
        logic [256:0] d;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = {ready, stateOut[287:256] + stateOut[255:224], stateOut[223:0]};
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL cycle_state t=%0t actual=%h required=%h", $time, d, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input logic [255:0] h);
        @(negedge clk);
        rst_n   = 1'b0;
        counter = 6'd63;
        wordIn  = $urandom;
        hashIn  = h;
        @(negedge clk);
        chk("reset_state", stateOut, {h[255:224], 32'h0, h[223:0]});
        chk("reset_ready", {287'h0, ready}, 288'h0);
    endtask

    task automatic run_rounds(input int last, input bit pin_abc);
        for (int t = 0; t <= last; t++) begin
            rst_n   = 1'b1;
            counter = 6'(t);
            wordIn  = (t < 16) ? msg[t] : $urandom;
            exp_q.push_back({t == 63, exp_st[t+1]});
            @(negedge clk);
            if (pin_abc && t == 0) begin
                chk("abc_r0_a", {256'h0, stateOut[287:256] + stateOut[255:224]}, {256'h0, 32'h5d6aebcd});
                chk("abc_r0_e", {256'h0, stateOut[127:96]}, {256'h0, 32'hfa2a4622});
            end
        end
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_model(h0_tb);
    endtask

    function automatic logic [255:0] dut_state();
        return {stateOut[287:256] + stateOut[255:224], stateOut[223:0]};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h;

        // K ROM sweep
        for (int a = 0; a < 64; a++) begin
            rom_addr = 6'(a);
            #1;
            chk($sformatf("k_rom_%0d", a), {256'h0, rom_val}, {256'h0, k_tb[a]});
        end
        chk("k_rom_lit0", {256'h0, k_tb[0]}, {256'h0, 32'h428a2f98});
        chk("k_rom_lit63", {256'h0, k_tb[63]}, {256'h0, 32'hc67178f2});

        // "abc" block; model pinned by literals
        load_abc();
        chk("model_r0_a", {256'h0, exp_st[1][255:224]}, {256'h0, 32'h5d6aebcd});
        chk("model_r0_e", {256'h0, exp_st[1][127:96]}, {256'h0, 32'hfa2a4622});
        chk("model_digest", {32'h0, add_words(exp_st[64], h0_tb)}, {32'h0, abc_digest});
        do_reset(h0_tb);
        run_rounds(63, 1'b1);
        chk("abc_ready", {287'h0, ready}, {287'h0, 1'b1});
        chk("abc_digest", {32'h0, add_words(dut_state(), h0_tb)}, {32'h0, abc_digest});

        // Hold: counter stuck at 63, random words
        for (int i = 0; i < 20; i++) begin
            counter = 6'd63;
            wordIn  = $urandom;
            exp_q.push_back({1'b1, exp_st[64]});
            @(negedge clk);
        end
        chk("hold_digest", {32'h0, add_words(dut_state(), h0_tb)}, {32'h0, abc_digest});

        // Restart: abort at round 30, rerun from scratch
        do_reset(h0_tb);
        run_rounds(30, 1'b0);
        do_reset(h0_tb);
        run_rounds(63, 1'b1);
        chk("restart_digest", {32'h0, add_words(dut_state(), h0_tb)}, {32'h0, abc_digest});

        // Random blocks with random chaining values
        for (int blk = 0; blk < 100; blk++) begin
            for (int i = 0; i < 16; i++) msg[i] = $urandom;
            for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
            build_model(h);
            do_reset(h);
            run_rounds(63, 1'b0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
